mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 133 +++++++++++++
 tb/tb_mult_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NUM_REQ requesters; one op in flight.
// Accept at T, mul_start at T+1, response the cycle after mul_done (or after TIMEOUT WAIT cycles); requesters wait via req_ready.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 20
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_a,
  input  logic [NUM_REQ*WIDTH-1:0]     req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]           rsp_product,
  output logic                         rsp_error,
  output logic                         mul_start,
  output logic [WIDTH-1:0]             mul_a,
  output logic [WIDTH-1:0]             mul_b,
  input  logic                         mul_done,
  input  logic [2*WIDTH-1:0]           mul_product,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       cap_id;
  logic [WIDTH-1:0]     cap_a;
  logic [WIDTH-1:0]     cap_b;
  logic [2*WIDTH-1:0]   product;
  logic                 err;
  logic [CW-1:0]        cnt;

  logic                 grant_vld;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       cand;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  // Search starts one past the last served requester so every requester gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDW'(k)) begin
        sel_a = req_a[k*WIDTH +: WIDTH];
        sel_b = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset && state == IDLE && grant_vld)
      req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      cap_id     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      product    <= '0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            cap_id  <= grant_idx;
            cap_a   <= sel_a;
            cap_b   <= sel_b;
            product <= '0;
            err     <= 1'b0;
            // A zero operand needs no multiplier round trip.
            state   <= (sel_a == '0 || sel_b == '0) ? RESP : ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            product <= mul_product;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          last_grant <= cap_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign mul_start   = (state == ISSUE);
  assign mul_a       = (state == ISSUE || state == WAIT) ? cap_a : '0;
  assign mul_b       = (state == ISSUE || state == WAIT) ? cap_b : '0;
  assign rsp_valid   = (state == RESP);
  assign rsp_id      = rsp_valid ? cap_id : '0;
  assign rsp_product = rsp_valid ? product : '0;
  assign rsp_error   = rsp_valid ? err : 1'b0;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
// An in-bench multiplier answers mul_start after a programmable delay.
module tb_mult_arbiter;

  localparam int NR  = 4;
  localparam int W   = 4;
  localparam int TO  = 20;
  localparam int IDW = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [NR-1:0]     req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_error;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic              mul_done = 1'b0;
  logic [2*W-1:0]    mul_product = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;

  int       mul_delay = 5;
  bit       mul_live  = 1'b1;
  bit       spur_en   = 1'b0;
  int       mul_cnt   = -1;
  logic [W-1:0] pend_ma, pend_mb;

  mult_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_error(rsp_error),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
  );

  always #5 clock = ~clock;

  // Multiplier stand-in: done fires mul_delay cycles after the start pulse; optional stray pulses when idle.
  always @(negedge clock) begin
    mul_done    = 1'b0;
    mul_product = '0;
    if (!reset) begin
      mul_cnt = -1;
    end else if (mul_start) begin
      pend_ma = mul_a;
      pend_mb = mul_b;
      mul_cnt = mul_delay;
    end else if (mul_cnt > 0) begin
      mul_cnt--;
      if (mul_cnt == 0) begin
        if (mul_live) begin
          mul_done    = 1'b1;
          mul_product = (2*W)'(pend_ma) * (2*W)'(pend_mb);
        end
        mul_cnt = -1;
      end
    end else if (spur_en && $urandom % 6 == 0) begin
      mul_done    = 1'b1;
      mul_product = (2*W)'($urandom);
    end
  end

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Drives one request set and records what the DUT did until the first response.
  task automatic run_op(input logic [NR-1:0] vld, input bit hold,
                        output logic [NR-1:0] rdy, output int n_start, output int t_start,
                        output logic [W-1:0] ma, output logic [W-1:0] mb, output int t_rsp,
                        output logic [IDW-1:0] id, output logic [2*W-1:0] prod,
                        output logic err, output bit leak);
    n_start = 0; t_start = -1; ma = '0; mb = '0; t_rsp = -1;
    id = '0; prod = '0; err = 1'b0; leak = 1'b0;
    req_valid = vld;
    @(negedge clock);
    rdy = req_ready;
    @(posedge clock);
    #1 if (!hold) req_valid = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clock);
      if (mul_start) begin
        n_start++; t_start = c; ma = mul_a; mb = mul_b;
      end
      if (rsp_valid) begin
        t_rsp = c; id = rsp_id; prod = rsp_product; err = rsp_error;
        break;
      end
      if ({rsp_id, rsp_product, rsp_error} !== '0) leak = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_ops(i, i + 1, i + 2);
    repeat (2) begin
      @(negedge clock);
      total++;
      if ({req_ready, rsp_valid, rsp_id, rsp_product, rsp_error, mul_start, mul_a, mul_b, busy} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got ready=%b rsp=%b mul_start=%b busy=%b want all 0",
                 req_ready, rsp_valid, mul_start, busy);
      end
    end
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_priority: got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    logic [NR-1:0] rdy; int ns, ts, tr; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    set_ops(0, 3, 5); mul_delay = 5; mul_live = 1'b1;
    run_op(4'b0001, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b want 0001", rdy); end
    total++; if (ns != 1 || ts != 1) begin bad++; $display("FAIL single_start: got %0d pulses at %0d want 1 at 1", ns, ts); end
    total++; if ({ma, mb} !== {4'd3, 4'd5}) begin bad++; $display("FAIL single_operands: got %0d,%0d want 3,5", ma, mb); end
    total++; if (tr != 7) begin bad++; $display("FAIL single_latency: got %0d want 7", tr); end
    total++; if ({id, prod, err} !== {2'd0, 8'd15, 1'b0}) begin
      bad++; $display("FAIL single_rsp: got id=%0d prod=%0d err=%b want 0,15,0", id, prod, err);
    end
    total++; if (leak) begin bad++; $display("FAIL single_rsp_idle: got nonzero rsp fields want 0"); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] rdy, er; int ns, ts, tr, d, e; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    int ra[NR], rb[NR];
    apply_reset();
    for (int i = 0; i < NR; i++) begin
      ra[i] = $urandom_range(1, 15); rb[i] = $urandom_range(1, 15);
      set_ops(i, ra[i], rb[i]);
    end
    for (int n = 0; n < 5; n++) begin
      e = n % NR;
      d = $urandom_range(1, TO); mul_delay = d; mul_live = 1'b1;
      run_op(4'b1111, 1'b1, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
      er = '0; er[e] = 1'b1;
      total++; if (rdy !== er) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", n, rdy, er); end
      total++; if (id !== IDW'(e) || prod !== (2*W)'(ra[e] * rb[e]) || err !== 1'b0 || tr != 2 + d) begin
        bad++;
        $display("FAIL rr_rsp[%0d]: got id=%0d prod=%0d err=%b t=%0d want %0d,%0d,0,%0d",
                 n, id, prod, err, tr, e, ra[e] * rb[e], 2 + d);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_zero_operand();
    logic [NR-1:0] rdy; int ns, ts, tr; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    set_ops(2, 0, 9);
    run_op(4'b0100, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (rdy !== 4'b0100 || ns != 0) begin
      bad++; $display("FAIL zero_a_issue: got ready=%b starts=%0d want 0100,0", rdy, ns);
    end
    total++; if (tr != 1 || {id, prod, err} !== {2'd2, 8'd0, 1'b0}) begin
      bad++; $display("FAIL zero_a_rsp: got t=%0d id=%0d prod=%0d err=%b want 1,2,0,0", tr, id, prod, err);
    end
    set_ops(1, 7, 0);
    run_op(4'b0010, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (ns != 0 || tr != 1 || {id, prod, err} !== {2'd1, 8'd0, 1'b0}) begin
      bad++; $display("FAIL zero_b_rsp: got starts=%0d t=%0d id=%0d prod=%0d want 0,1,1,0", ns, tr, id, prod);
    end
  endtask

  task automatic test_timeout();
    logic [NR-1:0] rdy; int ns, ts, tr; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    mul_live = 1'b0; mul_delay = 5;
    set_ops(0, 3, 4);
    run_op(4'b0001, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (ns != 1 || tr != 2 + TO || {id, prod, err} !== {2'd0, 8'd0, 1'b1}) begin
      bad++; $display("FAIL timeout_rsp: got starts=%0d t=%0d id=%0d prod=%0d err=%b want 1,%0d,0,0,1",
                      ns, tr, id, prod, err, 2 + TO);
    end
    mul_live = 1'b1; mul_delay = 4;
    set_ops(1, 6, 7);
    run_op(4'b0010, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (tr != 6 || {id, prod, err} !== {2'd1, 8'd42, 1'b0}) begin
      bad++; $display("FAIL timeout_recover: got t=%0d id=%0d prod=%0d err=%b want 6,1,42,0", tr, id, prod, err);
    end
    mul_delay = TO;
    set_ops(3, 9, 11);
    run_op(4'b1000, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (tr != 2 + TO || {id, prod, err} !== {2'd3, 8'd99, 1'b0}) begin
      bad++; $display("FAIL done_at_timeout: got t=%0d id=%0d prod=%0d err=%b want %0d,3,99,0",
                      tr, id, prod, err, 2 + TO);
    end
  endtask

  task automatic test_max_operand();
    logic [NR-1:0] rdy; int ns, ts, tr; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    mul_live = 1'b1; mul_delay = 3;
    set_ops(0, 15, 15);
    run_op(4'b0001, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (tr != 5 || prod !== 8'd225 || err !== 1'b0) begin
      bad++; $display("FAIL max_product: got t=%0d prod=%0d err=%b want 5,225,0", tr, prod, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0] rdy; int ns, ts, tr, stray; logic [W-1:0] ma, mb;
    logic [IDW-1:0] id; logic [2*W-1:0] prod; logic err; bit leak;
    mul_live = 1'b1; mul_delay = 15;
    set_ops(0, 5, 5);
    req_valid = 4'b0001;
    @(posedge clock);
    #1 req_valid = '0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_id, rsp_product, rsp_error, mul_start, mul_a, mul_b, busy} !== '0) begin
      bad++; $display("FAIL reset_mid_async: got busy=%b mul_a=%0d mul_b=%0d want all 0", busy, mul_a, mul_b);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid || mul_start || busy) stray++;
    end
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (25) begin
      @(negedge clock);
      if (rsp_valid || mul_start || busy) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL reset_mid_abort: got %0d active cycles want 0", stray); end
    @(posedge clock);
    #1;
    mul_delay = 2;
    set_ops(1, 2, 3); set_ops(2, 4, 5);
    run_op(4'b0110, 1'b0, rdy, ns, ts, ma, mb, tr, id, prod, err, leak);
    total++; if (rdy !== 4'b0010 || {id, prod, err} !== {2'd1, 8'd6, 1'b0}) begin
      bad++; $display("FAIL reset_mid_regrant: got ready=%b id=%0d prod=%0d want 0010,1,6", rdy, id, prod);
    end
  endtask

  function automatic int rnd_op();
    int r;
    r = $urandom % 8;
    if (r == 0) return 0;
    if (r == 1) return (1 << W) - 1;
    return $urandom_range(1, (1 << W) - 2);
  endfunction

  task automatic test_random();
    bit pend[NR];
    int pa[NR], pb[NR];
    bit inflight, exp_nz, exp_err, idle_now, exp_rsp, exp_start, allow_new, any;
    int age, last, exp_id, exp_rsp_age, w, cyc, nops;
    logic [2*W-1:0] exp_prod, exp_ops;
    logic [W-1:0] exp_a, exp_b;
    logic [NR-1:0] exp_rdy;
    inflight = 0; exp_nz = 0; exp_err = 0; allow_new = 1;
    age = 0; last = NR - 1; exp_id = 0; exp_rsp_age = 0; cyc = 0; nops = 0;
    exp_prod = '0; exp_a = '0; exp_b = '0;
    for (int i = 0; i < NR; i++) begin pend[i] = 0; pa[i] = 0; pb[i] = 0; end
    apply_reset();
    spur_en = 1'b1;
    while (1) begin
      @(negedge clock);
      idle_now = !inflight;
      if (inflight) age++;
      exp_rsp   = inflight && age == exp_rsp_age;
      exp_start = inflight && exp_nz && age == 1;
      exp_ops   = (inflight && exp_nz && age >= 1 && age < exp_rsp_age) ? {exp_a, exp_b} : '0;
      total++; if (busy !== inflight) begin bad++; $display("FAIL rand_busy@%0d: got %b want %b", cyc, busy, inflight); end
      total++; if (rsp_valid !== exp_rsp) begin bad++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, exp_rsp); end
      total++;
      if (exp_rsp ? ({rsp_id, rsp_product, rsp_error} !== {IDW'(exp_id), exp_prod, exp_err})
                  : ({rsp_id, rsp_product, rsp_error} !== '0)) begin
        bad++; $display("FAIL rand_rsp_data@%0d: got id=%0d prod=%0d err=%b want %0d,%0d,%b (valid %b)",
                        cyc, rsp_id, rsp_product, rsp_error, exp_id, exp_prod, exp_err, exp_rsp);
      end
      total++; if (mul_start !== exp_start) begin bad++; $display("FAIL rand_mul_start@%0d: got %b want %b", cyc, mul_start, exp_start); end
      total++; if ({mul_a, mul_b} !== exp_ops) begin bad++; $display("FAIL rand_mul_ops@%0d: got %h want %h", cyc, {mul_a, mul_b}, exp_ops); end
      if (exp_rsp) begin inflight = 0; last = exp_id; nops++; end
      exp_rdy = '0; w = -1;
      if (idle_now) begin
        for (int k = 1; k <= NR; k++) begin
          int j;
          j = (last + k) % NR;
          if (w < 0 && pend[j]) w = j;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
      if (w >= 0) begin
        inflight = 1; age = 0; exp_id = w; pend[w] = 0;
        exp_a = W'(pa[w]); exp_b = W'(pb[w]);
        exp_nz = (pa[w] != 0) && (pb[w] != 0);
        if (!exp_nz) begin
          exp_rsp_age = 1; exp_prod = '0; exp_err = 0;
        end else if ($urandom % 8 == 0) begin
          mul_live = 1'b0; mul_delay = TO + 5;
          exp_rsp_age = 2 + TO; exp_prod = '0; exp_err = 1;
        end else begin
          mul_live = 1'b1; mul_delay = $urandom_range(1, TO);
          exp_rsp_age = 2 + mul_delay; exp_prod = (2*W)'(pa[w] * pb[w]); exp_err = 0;
        end
      end
      cyc++;
      if (cyc >= 1500) allow_new = 0;
      any = 0;
      for (int i = 0; i < NR; i++) if (pend[i]) any = 1;
      if (!allow_new && !inflight && !any) break;
      if (cyc >= 2000) begin
        total++; bad++;
        $display("FAIL rand_drain: got inflight=%b pending=%b after %0d cycles want idle", inflight, any, cyc);
        break;
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (allow_new && !pend[i] && $urandom % 4 == 0) begin
          pend[i] = 1; pa[i] = rnd_op(); pb[i] = rnd_op();
        end else if (allow_new && pend[i] && $urandom % 20 == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = pend[i];
        set_ops(i, pa[i], pb[i]);
      end
    end
    spur_en = 1'b0; mul_live = 1'b1; req_valid = '0;
    total++; if (nops < 100) begin bad++; $display("FAIL rand_throughput: got %0d responses want >= 100", nops); end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_operand();
    test_timeout();
    test_max_operand();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
